// File: rtl/uart_tx_mmio_if.sv
// Core data-bus port into the UART transmitter register block.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; stores to a full FIFO are dropped by the slave, not stalled.
interface uart_tx_mmio_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_w;
  logic        d_r;
  logic        sel;
  logic [31:0] ddata_r;

  // Core side drives address, data and strobes; it receives the decode and read data.
  modport master (
    output daddr, ddata_w, d_w, d_r,
    input  sel, ddata_r
  );

  // Peripheral side decodes the address and returns combinational read data.
  modport slave (
    input  daddr, ddata_w, d_w, d_r,
    output sel, ddata_r
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by core stores, serialised on txd.
// Latency: push visible in count at the store edge; txd start bit begins one edge later when idle.
// Backpressure: none; a store to a full FIFO is dropped and sets the sticky overflow flag.

// Generic circular-buffer FIFO: push ignored when full, pop ignored when empty.
// Latency: head is combinational from storage; count updates at the push/pop edge.
// Backpressure: full/empty flags are pre-edge state; a same-cycle pop never frees room for a push.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module uart_tx_mmio #(
  parameter logic [9:0] BASE       = 10'h3F0,
  parameter int         CLK_DIV    = 434,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic           CLK,
  input  logic           RSTn,
  uart_tx_mmio_if.slave  bus,
  output logic           txd,
  output logic           irq
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] baud;
  logic [15:0] baud_nx;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_nx;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic        txd_nx;
  logic        irq_nx;
  logic        pop;
  logic        baud_done;

  logic [1:0]    offset;
  logic          push_req;
  logic          push_ok;
  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   status;

  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Upper store-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus.ddata_w[31:8];

  // ---------------- bus decode ----------------
  assign bus.sel  = (bus.daddr[9:2] == BASE[9:2]);
  assign offset   = bus.daddr[1:0];
  assign push_req = bus.sel & bus.d_w & (offset == 2'd0);
  assign push_ok  = push_req & ~fifo_full;
  assign ovf_set  = push_req & fifo_full;
  assign ovf_clr  = bus.sel & bus.d_w & (offset == 2'd1) & bus.ddata_w[3];

  // Assemble STATUS from pre-edge register state.
  always_comb begin
    status               = '0;
    status[0]            = (state != IDLE);
    status[1]            = fifo_full;
    status[2]            = fifo_empty;
    status[3]            = ovf;
    status[8 +: CW]      = fifo_count;
  end

  // Zero-latency read mux; only STATUS returns non-zero data.
  always_comb begin
    bus.ddata_r = '0;
    if (bus.sel && bus.d_r && offset == 2'd1) begin
      bus.ddata_r = status;
    end
  end

  fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.ddata_w[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- bit-timing FSM ----------------
  assign baud_done = (baud == BAUD_LAST);

  // Next-state logic; txd_nx is the line level for the state being entered so txd stays a flop.
  always_comb begin
    state_nx   = state;
    baud_nx    = baud;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    txd_nx     = txd;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        txd_nx = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          state_nx = START;
          baud_nx  = '0;
          txd_nx   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nx   = DATA;
          baud_nx    = '0;
          bit_idx_nx = '0;
          txd_nx     = shift[0];
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            txd_nx   = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            shift_nx   = {1'b0, shift[7:1]};
            txd_nx     = shift[1];
          end
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nx = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop      = 1'b1;
            shift_nx = fifo_dout;
            state_nx = START;
            txd_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
            txd_nx   = 1'b1;
          end
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = '0;
        txd_nx   = 1'b1;
      end
    endcase
  end

  // Entering IDLE implies the FIFO was empty before the edge and nothing popped,
  // so post-edge emptiness only depends on whether a store lands this cycle.
  assign irq_nx = (state_nx == IDLE) & fifo_empty & ~push_ok;

  // FSM, shifter and line registers; reset forces the line high immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      irq     <= 1'b1;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      txd     <= txd_nx;
      irq     <= irq_nx;
    end
  end

  // Sticky overflow; a dropped store in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8, BASE=0x3F0.
// Register decode is table driven; frame timing, overflow and reset are hand sequences.
// A serial monitor decodes txd and is compared against the bytes the bench accepted.
module tb_uart_tx_mmio;
  localparam int DIV = 4;

  logic CLK;
  logic RSTn;
  logic txd;
  logic irq;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .BASE       (10'h3F0),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus),
    .txd  (txd),
    .irq  (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        w;
    logic        r;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t       vecs [12];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];
  logic [7:0] mon_b;
  logic [7:0] pat;
  logic [31:0] rd;
  logic        exp_bit;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.daddr   = '0;
    bus.ddata_w = '0;
    bus.d_w     = 1'b0;
    bus.d_r     = 1'b0;
  endtask

  // Store lands at the next rising edge; returns 1 time unit after it.
  task automatic store(input logic [9:0] a, input logic [31:0] d);
    bus.daddr   = a;
    bus.ddata_w = d;
    bus.d_w     = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic read_reg(input logic [9:0] a, output logic [31:0] v);
    bus.daddr = a;
    bus.d_r   = 1'b1;
    #1;
    v = bus.ddata_r;
    bus.d_r   = 1'b0;
    bus.daddr = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: irq still %b after %0d cycles, required 1", name, irq, budget);
    end
  endtask

  // Serial monitor: sample mid-bit on the falling edge after seeing a start bit.
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTn === 1'b1 && txd === 1'b0) begin
        repeat (DIV / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          mon_b[i] = txd;
        end
        repeat (DIV) @(negedge CLK);
        rx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    vecs[0]  = '{10'h3F1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0004};
    vecs[1]  = '{10'h3F0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[2]  = '{10'h3F2, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[3]  = '{10'h3F3, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{10'h3F4, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[5]  = '{10'h3EF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[6]  = '{10'h3F1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7]  = '{10'h3F2, 32'h0000_00AA, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{10'h3F4, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{10'h3F3, 32'h0000_0077, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
    vecs[10] = '{10'h3F1, 32'h0000_00FF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[11] = '{10'h3F1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0004};

    RSTn = 1'b0;
    bus_idle();
    step();
    step();
    RSTn = 1'b1;
    step();
    check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd1);

    // ---- register decode table ----
    for (int i = 0; i < 12; i++) begin
      bus.daddr   = vecs[i].addr;
      bus.ddata_w = vecs[i].wdata;
      bus.d_w     = vecs[i].w;
      bus.d_r     = vecs[i].r;
      #1;
      check($sformatf("vec%0d_sel", i), {31'b0, bus.sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("vec%0d_rdata", i), bus.ddata_r, vecs[i].exp_rdata);
      step();
      bus_idle();
    end
    check("table_txd_idle", {31'b0, txd}, 32'd1);
    check("table_irq_idle", {31'b0, irq}, 32'd1);

    // ---- single frame 0xA5, cycle-exact ----
    pat = 8'hA5;
    store(10'h3F0, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    check("a5_txd_at_push", {31'b0, txd}, 32'd1);
    check("a5_irq_fall", {31'b0, irq}, 32'd0);
    read_reg(10'h3F1, rd);
    check("a5_status_push", rd, 32'h0000_0100);
    step();
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k < DIV)            exp_bit = 1'b0;
      else if (k < 9 * DIV)   exp_bit = pat[(k - DIV) / DIV];
      else                    exp_bit = 1'b1;
      check($sformatf("a5_txd_k%0d", k), {31'b0, txd}, {31'b0, exp_bit});
      if (k == 0) begin
        read_reg(10'h3F1, rd);
        check("a5_status_start", rd, 32'h0000_0005);
      end
      step();
    end
    step();
    step();
    check("a5_irq_rise", {31'b0, irq}, 32'd1);
    read_reg(10'h3F1, rd);
    check("a5_status_done", rd, 32'h0000_0004);

    // ---- three back-to-back frames ----
    store(10'h3F0, 32'h0000_0001);
    store(10'h3F0, 32'h0000_0002);
    store(10'h3F0, 32'h0000_0003);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    read_reg(10'h3F1, rd);
    check("b2b_status_cnt2", rd, 32'h0000_0201);
    check("b2b_f1_start", {31'b0, txd}, 32'd0);
    repeat (38) step();
    check("b2b_f1_stop", {31'b0, txd}, 32'd1);
    step();
    check("b2b_f2_start", {31'b0, txd}, 32'd0);
    repeat (39) step();
    check("b2b_f2_stop", {31'b0, txd}, 32'd1);
    step();
    check("b2b_f3_start", {31'b0, txd}, 32'd0);
    check("b2b_irq_busy", {31'b0, irq}, 32'd0);
    wait_idle("b2b_wait_idle", 100);
    step();
    read_reg(10'h3F1, rd);
    check("b2b_status_done", rd, 32'h0000_0004);

    // ---- overflow: 10 stores in 10 cycles ----
    for (int i = 0; i < 10; i++) begin
      store(10'h3F0, 32'h10 + i);
      if (i < 9) exp_q.push_back(8'(8'h10 + i));
    end
    read_reg(10'h3F1, rd);
    check("ovf_status_full", rd, 32'h0000_080B);
    store(10'h3F1, 32'h0000_0008);
    read_reg(10'h3F1, rd);
    check("ovf_status_clr", rd, 32'h0000_0803);
    repeat (30) step();
    check("ovf_f1_stop", {31'b0, txd}, 32'd1);
    // This store hits the edge where frame 1 ends and the head pops: still dropped.
    store(10'h3F0, 32'h0000_00EE);
    read_reg(10'h3F1, rd);
    check("ovf_pop_push_full", rd, 32'h0000_0709);
    check("ovf_f2_start", {31'b0, txd}, 32'd0);
    store(10'h3F1, 32'h0000_0008);
    read_reg(10'h3F1, rd);
    check("ovf_status_clr2", rd, 32'h0000_0701);
    wait_idle("ovf_wait_idle", 600);
    step();
    step();

    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    end

    // ---- asynchronous reset mid-frame ----
    store(10'h3F0, 32'h0000_005A);
    store(10'h3F0, 32'h0000_005B);
    repeat (4) step();
    check("rst_pre_txd", {31'b0, txd}, 32'd0);
    check("rst_pre_irq", {31'b0, irq}, 32'd0);
    #2;
    RSTn = 1'b0;
    #1;
    check("rst_async_txd", {31'b0, txd}, 32'd1);
    check("rst_async_irq", {31'b0, irq}, 32'd1);
    step();
    step();
    RSTn = 1'b1;
    step();
    read_reg(10'h3F1, rd);
    check("rst_status", rd, 32'h0000_0004);
    repeat (3) step();
    check("rst_txd_stays_idle", {31'b0, txd}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
